// File: rtl/counter_sequencer.sv
// Prescaled up-counter sequencer with run/pause/done control and one-shot or auto-reload modes.
// All outputs come straight from registers; control priority is reset > clear > stop > start.
module counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int PWIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              reload,
    input  logic [WIDTH-1:0]  tc_value,
    input  logic [PWIDTH-1:0] prescale,
    output logic [WIDTH-1:0]  count,
    output logic [1:0]        state,
    output logic              busy,
    output logic              tick,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  tc_q, tc_d;
    logic [PWIDTH-1:0] pcnt_q, pcnt_d;
    logic [PWIDTH-1:0] ps_q, ps_d;
    logic              reload_q, reload_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            tc_q     <= '0;
            pcnt_q   <= '0;
            ps_q     <= '0;
            reload_q <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tc_q     <= tc_d;
            pcnt_q   <= pcnt_d;
            ps_q     <= ps_d;
            reload_q <= reload_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tc_d     = tc_q;
        pcnt_d   = pcnt_q;
        ps_d     = ps_q;
        reload_d = reload_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;

        if (clear) begin
            // Clear wins even over a coinciding terminal tick, so no done escapes.
            state_d = S_IDLE;
            count_d = '0;
            pcnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        tc_d     = tc_value;
                        ps_d     = prescale;
                        reload_d = reload;
                        count_d  = '0;
                        pcnt_d   = '0;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_PAUSE;
                    end else if (pcnt_q != ps_q) begin
                        pcnt_d = pcnt_q + 1'b1;
                    end else begin
                        pcnt_d = '0;
                        tick_d = 1'b1;
                        if (count_q != tc_q) begin
                            count_d = count_q + 1'b1;
                        end else begin
                            done_d = 1'b1;
                            if (reload_q) begin
                                count_d = '0;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (!stop && start) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    end

    assign count = count_q;
    assign state = state_q;
    assign busy  = busy_q;
    assign tick  = tick_q;
    assign done  = done_q;

endmodule
